ped_request_unit: RTL and testbench
===================================

# ped_request_unit

Pedestrian-request front end for the intersection controller. Synchronizes and debounces the raw crossing push-button, latches a request until the controller grants a pedestrian phase, and drives the "WAIT" indicator. After each pedestrian phase it enforces a lockout before a new request can be raised, and it counts accepted requests for diagnostics. It sits directly upstream of the traffic-light controller: `req` feeds the controller's button input, and the controller's pedestrian-green indication returns as `ped_phase`.

## Interface
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive cycles a changed level must persist before it is accepted (must be ≥1).
- `LOCKOUT_CYCLES`, 500_000_000: cycles after a pedestrian phase ends during which no request is issued (must be ≥1).
- `CNT_W`, 16: width of the request counter.
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `button_raw` in 1: raw push-button, asynchronous to `clk`, active-high.
- `ped_phase` in 1: high while the controller shows pedestrian green (steady or blinking); synchronous to `clk`.
- `req` out 1: pedestrian request to the controller; level held until service begins.
- `wait_lamp` out 1: "WAIT" indicator; identical to `req`.
- `req_count` out CNT_W: number of accepted requests; saturates at all-ones.

## Operation
- **Synchronizer:** two flops, `button_raw` → `btn_sync`.
- **Debouncer:**
  - A counter counts the consecutive cycles in which `btn_sync` differs from `btn_stable`. Any cycle in which they are equal clears the counter to 0.
  - When the count reaches DEBOUNCE_CYCLES−1 while they still differ, `btn_stable` takes the `btn_sync` value and the counter clears.
  - `press_evt` is a one-cycle combinational pulse, asserted on the cycle `btn_stable` goes 0→1.
- **Phase edge detect:**
  - `ped_d` is `ped_phase` registered.
  - `ped_rise` = `ped_phase & ~ped_d`.
  - `ped_fall` = `~ped_phase & ped_d`.
- **FSM states:** IDLE, REQUESTED, SERVING, LOCKOUT, plus a `pending` flag.
  - **IDLE:** `ped_rise` → SERVING (takes priority). Otherwise `press_evt` → REQUESTED and `req_count` increments.
  - **REQUESTED:** `req`=1. `ped_rise` → SERVING. Presses are ignored.
  - **SERVING:** `ped_fall` → LOCKOUT, with the lockout counter cleared and `pending` cleared. Presses are ignored.
  - **LOCKOUT:**
    - The lockout counter increments every cycle.
    - `press_evt` sets `pending`.
    - When the counter reaches LOCKOUT_CYCLES−1: if `pending`, go to REQUESTED, increment `req_count` and clear `pending`; otherwise go to IDLE.
    - `ped_rise` in LOCKOUT overrides everything: go to SERVING and clear `pending`.
  - Unused or illegal state encodings → IDLE.
- **Outputs:** `req` = `wait_lamp` = (state == REQUESTED). Both are driven from a register, so they are glitch-free.
- **Counter:** `req_count` increments by 1 on each REQUESTED entry. It holds at 2^CNT_W−1 and does not wrap.
- **Button release:** releasing the button has no effect on the FSM. It only returns `btn_stable` to 0 after debounce.

## Timing
- **Reset values:**
  - `req`=0, `wait_lamp`=0, `req_count`=0.
  - state IDLE, `btn_stable`=0, `pending`=0, `ped_d`=0, all counters 0.
- **Reset mid-operation:** immediate asynchronous clear. Any pending or latched request is lost.
- **Press latency:** take `button_raw` high and held from edge E0 (first sampled at E0).
  - `btn_sync`=1 after E1.
  - `btn_stable`=1 after E1+DEBOUNCE_CYCLES.
  - `req`=1 after the following edge, i.e. E2+DEBOUNCE_CYCLES.
- **Glitch rejection:** a pulse shorter than DEBOUNCE_CYCLES cycles at `btn_sync` produces no `press_evt`.
- **Service latency:** `req` drops on the edge that samples `ped_phase`=1 for the first time.
- **Lockout length:** exactly LOCKOUT_CYCLES cycles in LOCKOUT, counted from the edge that samples `ped_phase` falling.
- **Simultaneous events:**
  - `ped_rise` and `press_evt` in the same cycle → SERVING, no count.
  - A press on the final lockout cycle sets `pending` and is honoured: → REQUESTED.
- **Held button:** a button held through the whole lockout does not re-trigger. A new 0→1 on `btn_stable` is required.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=10, CNT_W=4.
1. Reset, then hold `button_raw`=1 → `req` and `wait_lamp` rise exactly 6 edges after the first sampling edge; `req_count`=1.
2. Pulse `button_raw` high for 3 cycles, then low → `req` stays 0 and `req_count` stays 0. A 4-cycle pulse → `req`=1.
3. With `req`=1, raise `ped_phase` → `req`=0 on the next edge. Hold 20 cycles, drop `ped_phase`, then press once at lockout cycle 3 → `req` stays 0 until the lockout counter hits 9, then `req`=1 on that edge; `req_count`=2.
4. Raise `ped_phase` and a `press_evt` in the same cycle from IDLE → state SERVING, `req` never asserts, `req_count` unchanged.
5. Generate 17 accepted requests, each served and locked out → `req_count` ends at 15, with no wrap.
6. Assert `rst` while `req`=1 and during LOCKOUT with `pending`=1 → all outputs are 0 immediately. After release, no request is raised without a new press.

Source files
------------

// File: rtl/ped_request_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ped_request_unit
// Description : Pedestrian-request front end for the intersection controller.
//               Synchronizes and debounces the raw crossing push-button,
//               latches a request until the controller grants a pedestrian
//               phase, drives the WAIT lamp, enforces a post-phase lockout
//               and counts accepted requests (saturating).
// Ports       : clk        - system clock
//               rst        - asynchronous active-high reset
//               button_raw - raw push-button, asynchronous to clk
//               ped_phase  - controller pedestrian-green indication
//               req        - registered request level to the controller
//               wait_lamp  - WAIT indicator, identical to req
//               req_count  - accepted request count, saturates at all-ones
// Revision    : 1.0 - initial release
// ============================================================================
module ped_request_unit #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LOCKOUT_CYCLES  = 500_000_000,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             button_raw,
  input  logic             ped_phase,
  output logic             req,
  output logic             wait_lamp,
  output logic [CNT_W-1:0] req_count
);

  // Counters only ever reach N-1, so clog2(N) bits suffice (min 1 bit).
  localparam int c_db_w = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int c_lo_w = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [c_db_w-1:0] c_db_last = c_db_w'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_lo_w-1:0] c_lo_last = c_lo_w'(LOCKOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_REQUESTED = 2'd1,
    ST_SERVING   = 2'd2,
    ST_LOCKOUT   = 2'd3
  } state_t;

  logic              r_sync_meta;
  logic              r_btn_sync;
  logic              r_btn_stable;
  logic              r_btn_stable_d;
  logic [c_db_w-1:0] r_db_cnt;
  logic              r_ped_d;
  state_t            r_state;
  logic              r_pending;
  logic [c_lo_w-1:0] r_lo_cnt;
  logic              r_req;
  logic [CNT_W-1:0]  r_req_count;

  logic w_press_evt;
  logic w_ped_rise;
  logic w_ped_fall;
  logic w_cnt_full;

  // Two-flop synchronizer for the asynchronous button.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync_meta <= 1'b0;
      r_btn_sync  <= 1'b0;
    end else begin
      r_sync_meta <= button_raw;
      r_btn_sync  <= r_sync_meta;
    end
  end

  // Debouncer: a new level is accepted only after it has differed from the
  // stable level for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_btn_stable   <= 1'b0;
      r_btn_stable_d <= 1'b0;
      r_db_cnt       <= '0;
    end else begin
      r_btn_stable_d <= r_btn_stable;
      if (r_btn_sync != r_btn_stable) begin
        if (r_db_cnt == c_db_last) begin
          r_btn_stable <= r_btn_sync;
          r_db_cnt     <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + 1'b1;
        end
      end else begin
        r_db_cnt <= '0;
      end
    end
  end

  assign w_press_evt = r_btn_stable & ~r_btn_stable_d;

  // Pedestrian phase edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ped_d <= 1'b0;
    end else begin
      r_ped_d <= ped_phase;
    end
  end

  assign w_ped_rise = ped_phase & ~r_ped_d;
  assign w_ped_fall = ~ped_phase & r_ped_d;
  assign w_cnt_full = &r_req_count;

  // Request FSM. r_req is updated on every transition into or out of
  // REQUESTED so it always equals (state == REQUESTED) from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_pending   <= 1'b0;
      r_lo_cnt    <= '0;
      r_req       <= 1'b0;
      r_req_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // A phase starting on the same cycle as a press wins: no count.
          if (w_ped_rise) begin
            r_state <= ST_SERVING;
          end else if (w_press_evt) begin
            r_state <= ST_REQUESTED;
            r_req   <= 1'b1;
            if (!w_cnt_full) begin
              r_req_count <= r_req_count + 1'b1;
            end
          end
        end
        ST_REQUESTED: begin
          if (w_ped_rise) begin
            r_state <= ST_SERVING;
            r_req   <= 1'b0;
          end
        end
        ST_SERVING: begin
          if (w_ped_fall) begin
            r_state   <= ST_LOCKOUT;
            r_lo_cnt  <= '0;
            r_pending <= 1'b0;
          end
        end
        ST_LOCKOUT: begin
          if (w_ped_rise) begin
            r_state   <= ST_SERVING;
            r_pending <= 1'b0;
          end else if (r_lo_cnt == c_lo_last) begin
            // A press on the final lockout cycle still counts as pending.
            r_lo_cnt  <= '0;
            r_pending <= 1'b0;
            if (r_pending | w_press_evt) begin
              r_state <= ST_REQUESTED;
              r_req   <= 1'b1;
              if (!w_cnt_full) begin
                r_req_count <= r_req_count + 1'b1;
              end
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_lo_cnt <= r_lo_cnt + 1'b1;
            if (w_press_evt) begin
              r_pending <= 1'b1;
            end
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_req     <= 1'b0;
          r_pending <= 1'b0;
        end
      endcase
    end
  end

  assign req       = r_req;
  assign wait_lamp = r_req;
  assign req_count = r_req_count;

endmodule
`default_nettype wire

// File: tb/tb_ped_request_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ped_request_unit
// Description : Self-checking bench for ped_request_unit (DEBOUNCE_CYCLES=4,
//               LOCKOUT_CYCLES=10, CNT_W=4). Inputs change and outputs are
//               sampled on the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ped_request_unit;

  localparam int c_d   = 4;
  localparam int c_l   = 10;
  localparam int c_cw  = 4;
  localparam int c_max = (1 << c_cw) - 1;

  logic            clk;
  logic            rst;
  logic            button_raw;
  logic            ped_phase;
  logic            req;
  logic            wait_lamp;
  logic [c_cw-1:0] req_count;

  int errors = 0;
  int checks = 0;

  ped_request_unit #(
    .DEBOUNCE_CYCLES(c_d),
    .LOCKOUT_CYCLES (c_l),
    .CNT_W          (c_cw)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .button_raw(button_raw),
    .ped_phase (ped_phase),
    .req       (req),
    .wait_lamp (wait_lamp),
    .req_count (req_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int idx, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, got, exp);
    end
  endtask

  task automatic check_outs(input string name, input int idx, input int exp_req, input int exp_cnt);
    check({name, "_req"}, idx, int'(req), exp_req);
    check({name, "_lamp"}, idx, int'(wait_lamp), exp_req);
    check({name, "_cnt"}, idx, int'(req_count), exp_cnt);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; button_raw = 1'b0; ped_phase = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Waits (bounded) at falling edges for req to assert.
  task automatic wait_req(input int idx);
    bit seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (req) begin
        seen = 1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL wait_req[%0d]: got req=0 expected req=1 within 30 cycles", idx);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Button path: a shift pipeline plus a run-length of differing samples.
  // Controller: a mode flag and a lockout countdown of remaining cycles.
  bit m_s1, m_sync, m_stable, m_stable_q, m_ped_q, m_pend, m_req;
  int m_run, m_mode, m_left, m_cnt;   // mode: 0 idle, 1 waiting, 2 green, 3 locked

  function automatic void model_reset();
    m_s1 = 0; m_sync = 0; m_stable = 0; m_stable_q = 0; m_ped_q = 0;
    m_pend = 0; m_req = 0; m_run = 0; m_mode = 0; m_left = 0; m_cnt = 0;
  endfunction

  function automatic void model_bump();
    if (m_cnt < c_max) m_cnt = m_cnt + 1;
  endfunction

  // One rising clock edge with inputs b, p.
  function automatic void model_edge(bit b, bit p);
    bit press, rise, fall, n_stable;
    int n_run;
    press = m_stable && !m_stable_q;
    rise  = p && !m_ped_q;
    fall  = !p && m_ped_q;
    n_stable = m_stable;
    n_run    = 0;
    if (m_sync != m_stable) begin
      n_run = m_run + 1;
      if (n_run >= c_d) begin
        n_stable = m_sync;
        n_run    = 0;
      end
    end
    m_stable_q = m_stable;
    m_stable   = n_stable;
    m_run      = n_run;
    m_sync     = m_s1;
    m_s1       = b;
    m_ped_q    = p;
    case (m_mode)
      0: if (rise) m_mode = 2; else if (press) begin m_mode = 1; model_bump(); end
      1: if (rise) m_mode = 2;
      2: if (fall) begin m_mode = 3; m_left = c_l; m_pend = 0; end
      default: begin
        if (rise) begin
          m_mode = 2; m_pend = 0;
        end else begin
          m_left = m_left - 1;
          if (press) m_pend = 1;
          if (m_left == 0) begin
            if (m_pend) begin m_mode = 1; model_bump(); end
            else m_mode = 0;
            m_pend = 0;
          end
        end
      end
    endcase
    m_req = (m_mode == 1);
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic rst;
    logic btn;
    logic ped;
    int   n;
    int   exp_req;
    int   exp_cnt;
  } vec_t;

  vec_t tbl[16];

  initial begin
    bit b, p, r, r_prev;

    rst = 1'b1; button_raw = 1'b0; ped_phase = 1'b0;

    tbl[0]  = '{1'b1, 1'b0, 1'b0,  2, 0, 0};  // reset state
    tbl[1]  = '{1'b0, 1'b1, 1'b0,  6, 0, 0};  // held press, before latency
    tbl[2]  = '{1'b0, 1'b1, 1'b0,  1, 1, 1};  // req on 7th edge (E6)
    tbl[3]  = '{1'b0, 1'b0, 1'b1,  1, 0, 1};  // service drops req at once
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 19, 0, 1};
    tbl[5]  = '{1'b0, 1'b0, 1'b0,  1, 0, 1};  // phase falls -> lockout
    tbl[6]  = '{1'b0, 1'b1, 1'b0,  8, 0, 1};  // press during lockout
    tbl[7]  = '{1'b0, 1'b1, 1'b0,  1, 0, 1};  // lockout cycle 9 still locked
    tbl[8]  = '{1'b0, 1'b1, 1'b0,  1, 1, 2};  // pending honoured at end
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 10, 1, 2};  // level held until service
    tbl[10] = '{1'b1, 1'b0, 1'b0,  2, 0, 0};
    tbl[11] = '{1'b0, 1'b1, 1'b0,  3, 0, 0};  // 3-cycle glitch
    tbl[12] = '{1'b0, 1'b0, 1'b0, 10, 0, 0};
    tbl[13] = '{1'b0, 1'b1, 1'b0,  4, 0, 0};  // 4-cycle pulse
    tbl[14] = '{1'b0, 1'b0, 1'b0,  2, 0, 0};
    tbl[15] = '{1'b0, 1'b0, 1'b0,  1, 1, 1};  // accepted

    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      rst = tbl[i].rst; button_raw = tbl[i].btn; ped_phase = tbl[i].ped;
      repeat (tbl[i].n) @(negedge clk);
      check_outs("tbl", i, tbl[i].exp_req, tbl[i].exp_cnt);
    end

    // ---- phase rise and press event on the same edge from IDLE ----
    do_reset();
    @(negedge clk);
    button_raw = 1'b1;
    repeat (6) @(negedge clk);    // now between E5 and E6: press_evt high
    ped_phase = 1'b1;
    @(negedge clk);
    check_outs("simul", 0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("simul_hold_req", k, int'(req), 0);
    end
    ped_phase = 1'b0;             // lockout with the button still held
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      check("held_req", k, int'(req), 0);
    end
    check("held_cnt", 0, int'(req_count), 0);
    button_raw = 1'b0;
    repeat (8) @(negedge clk);
    button_raw = 1'b1;            // fresh press from IDLE
    wait_req(0);
    check("repress_cnt", 0, int'(req_count), 1);
    button_raw = 1'b0;

    // ---- 17 served requests: counter saturates ----
    do_reset();
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      button_raw = 1'b1;
      wait_req(100 + i);
      button_raw = 1'b0;
      check("sat_cnt", i, int'(req_count), (i + 1 > c_max) ? c_max : i + 1);
      ped_phase = 1'b1;
      repeat (3) @(negedge clk);
      check("sat_served", i, int'(req), 0);
      ped_phase = 1'b0;
      repeat (12) @(negedge clk);
    end

    // ---- reset while requested ----
    do_reset();
    @(negedge clk);
    button_raw = 1'b1;
    wait_req(200);
    #2 rst = 1'b1;
    #1 check_outs("rst_req", 0, 0, 0);
    @(negedge clk);
    button_raw = 1'b0;
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check_outs("rst_req_after", 0, 0, 0);

    // ---- reset during lockout with a pending press ----
    button_raw = 1'b1;
    wait_req(201);
    button_raw = 1'b0;
    ped_phase = 1'b1;
    repeat (3) @(negedge clk);
    ped_phase = 1'b0;
    @(negedge clk);               // lockout entered
    button_raw = 1'b1;
    repeat (8) @(negedge clk);    // pending now set
    #2 rst = 1'b1;
    #1 check_outs("rst_lock", 0, 0, 0);
    @(negedge clk);
    button_raw = 1'b0;
    rst = 1'b0;
    repeat (25) @(negedge clk);
    check_outs("rst_lock_after", 0, 0, 0);

    // ---- randomized run against the reference model ----
    do_reset();
    model_reset();
    b = 0; p = 0; r_prev = 0;
    @(negedge clk);
    for (int c = 0; c < 600; c++) begin
      check("rnd_req", c, int'(req), int'(m_req));
      check("rnd_lamp", c, int'(wait_lamp), int'(m_req));
      check("rnd_cnt", c, int'(req_count), m_cnt);
      if ($urandom_range(0, 4) == 0) b = ~b;
      if ($urandom_range(0, 9) == 0) p = ~p;
      r = !r_prev && ($urandom_range(0, 149) == 0);
      button_raw = b; ped_phase = p; rst = r;
      if (r) model_reset();
      else   model_edge(b, p);
      r_prev = r;
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
